// File: rtl/perf_counter_unit.sv
// Retirement/instruction-class performance counters with registered readback.
// Optional sampling-window logic is compiled in when PERF_WINDOW_EN is defined.
module perf_counter_unit #(
  parameter int CNT_WIDTH     = 32,
  parameter int WINDOW_CYCLES = 1000
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 valid_wb_i,
  input  logic                 stall_wb_i,
  input  logic [31:0]          instr_wb_i,
  input  logic                 clear_i,
  input  logic                 freeze_i,
  input  logic [2:0]           sel_i,
  output logic [CNT_WIDTH-1:0] rd_data_o,
  output logic                 window_done_o,
  output logic [CNT_WIDTH-1:0] window_retire_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [31:0]          NOP_INSTR = 32'h0000_0013;

  localparam logic [2:0] IDX_CYCLE  = 3'd0;
  localparam logic [2:0] IDX_RETIRE = 3'd1;
  localparam logic [2:0] IDX_ALU    = 3'd2;
  localparam logic [2:0] IDX_LOAD   = 3'd3;
  localparam logic [2:0] IDX_STORE  = 3'd4;
  localparam logic [2:0] IDX_BRANCH = 3'd5;
  localparam logic [2:0] IDX_OTHER  = 3'd6;
  localparam logic [2:0] IDX_NONE   = 3'd7;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic                 retire_s;
  logic [2:0]           class_idx_s;
  logic [CNT_WIDTH-1:0] cnt_q [7];
  logic [CNT_WIDTH-1:0] cnt_d [7];
  logic [CNT_WIDTH-1:0] rd_data_q;
  logic [CNT_WIDTH-1:0] rd_data_d;

  assign retire_s = valid_wb_i & ~stall_wb_i & (instr_wb_i != NOP_INSTR);

  // Opcode to instruction-class counter index.
  always_comb begin
    class_idx_s = IDX_OTHER;
    case (instr_wb_i[6:0])
      7'b0110011, 7'b0010011, 7'b0010111, 7'b0110111: class_idx_s = IDX_ALU;
      7'b1100011, 7'b1101111, 7'b1100111:             class_idx_s = IDX_BRANCH;
      7'b0000011:                                     class_idx_s = IDX_LOAD;
      7'b0100011:                                     class_idx_s = IDX_STORE;
      default:                                        class_idx_s = IDX_OTHER;
    endcase
  end

  // Counter next-state: clear beats freeze beats increment.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (clear_i) begin
      for (int i = 0; i < 7; i++) begin
        cnt_d[i] = CNT_ZERO;
      end
    end else if (!freeze_i) begin
      cnt_d[IDX_CYCLE] = sat_inc(cnt_q[IDX_CYCLE]);
      if (retire_s) begin
        cnt_d[IDX_RETIRE]  = sat_inc(cnt_q[IDX_RETIRE]);
        cnt_d[class_idx_s] = sat_inc(cnt_q[class_idx_s]);
      end else begin
        cnt_d[IDX_RETIRE] = cnt_q[IDX_RETIRE];
      end
    end else begin
      cnt_d[IDX_CYCLE] = cnt_q[IDX_CYCLE];
    end
  end

  // Readback mux samples the pre-update counter value.
  always_comb begin
    if (sel_i == IDX_NONE) begin
      rd_data_d = CNT_ZERO;
    end else begin
      rd_data_d = cnt_q[sel_i];
    end
  end

  // Counter and readback registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 7; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
      rd_data_q <= CNT_ZERO;
    end else begin
      for (int i = 0; i < 7; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

`ifdef PERF_WINDOW_EN
  localparam logic [CNT_WIDTH-1:0] WIN_LAST = CNT_WIDTH'(WINDOW_CYCLES - 1);

  logic [CNT_WIDTH-1:0] win_cnt_q;
  logic [CNT_WIDTH-1:0] win_cnt_d;
  logic [CNT_WIDTH-1:0] win_acc_q;
  logic [CNT_WIDTH-1:0] win_acc_d;
  logic [CNT_WIDTH-1:0] win_retire_q;
  logic [CNT_WIDTH-1:0] win_retire_d;
  logic                 win_done_q;
  logic                 win_done_d;
  logic [CNT_WIDTH-1:0] acc_next_s;

  // Window next-state; the closing edge's own retire joins the published total.
  always_comb begin
    acc_next_s   = retire_s ? sat_inc(win_acc_q) : win_acc_q;
    win_cnt_d    = win_cnt_q;
    win_acc_d    = win_acc_q;
    win_retire_d = win_retire_q;
    win_done_d   = 1'b0;
    if (clear_i) begin
      win_cnt_d = CNT_ZERO;
      win_acc_d = CNT_ZERO;
    end else if (freeze_i) begin
      win_cnt_d = win_cnt_q;
    end else if (win_cnt_q == WIN_LAST) begin
      win_cnt_d    = CNT_ZERO;
      win_acc_d    = CNT_ZERO;
      win_retire_d = acc_next_s;
      win_done_d   = 1'b1;
    end else begin
      win_cnt_d = win_cnt_q + CNT_ONE;
      win_acc_d = acc_next_s;
    end
  end

  // Window registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      win_cnt_q    <= CNT_ZERO;
      win_acc_q    <= CNT_ZERO;
      win_retire_q <= CNT_ZERO;
      win_done_q   <= 1'b0;
    end else begin
      win_cnt_q    <= win_cnt_d;
      win_acc_q    <= win_acc_d;
      win_retire_q <= win_retire_d;
      win_done_q   <= win_done_d;
    end
  end

  assign window_done_o   = win_done_q;
  assign window_retire_o = win_retire_q;
`else
  assign window_done_o   = 1'b0;
  assign window_retire_o = CNT_ZERO;
`endif

endmodule

// File: tb/tb_perf_counter_unit.sv
// Randomized self-checking bench for perf_counter_unit (CNT_WIDTH=8, WINDOW_CYCLES=8)
// against an integer reference model; window checks follow PERF_WINDOW_EN.
module tb_perf_counter_unit;

  localparam int CW   = 8;
  localparam int W    = 8;
  localparam int MAXV = 255;
`ifdef PERF_WINDOW_EN
  localparam bit WIN_EN = 1'b1;
`else
  localparam bit WIN_EN = 1'b0;
`endif

  localparam logic [31:0] ALU_I = 32'h00B5_0533;
  localparam logic [31:0] LD_I  = 32'h0005_A503;
  localparam logic [31:0] ST_I  = 32'h00B5_2023;
  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b1;
  logic          valid_wb_i = 1'b0;
  logic          stall_wb_i = 1'b0;
  logic [31:0]   instr_wb_i = 32'h0;
  logic          clear_i = 1'b0;
  logic          freeze_i = 1'b0;
  logic [2:0]    sel_i = 3'd0;
  logic [CW-1:0] rd_data_o;
  logic          window_done_o;
  logic [CW-1:0] window_retire_o;

  perf_counter_unit #(.CNT_WIDTH(CW), .WINDOW_CYCLES(W)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .valid_wb_i(valid_wb_i),
    .stall_wb_i(stall_wb_i), .instr_wb_i(instr_wb_i), .clear_i(clear_i),
    .freeze_i(freeze_i), .sel_i(sel_i), .rd_data_o(rd_data_o),
    .window_done_o(window_done_o), .window_retire_o(window_retire_o)
  );

  always #5 clk_i = ~clk_i;

  int nchk = 0;
  int nerr = 0;
  bit cmp_en = 1'b0;

  // Reference model state: plain integers, saturated by arithmetic.
  int m_cnt [7];
  int m_rd, m_pos, m_acc, m_wret;
  bit m_done;
  bit m_ret;

  function automatic int sat(input int x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  function automatic int op_class(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    case (op)
      7'h33, 7'h13, 7'h17, 7'h37: return 2;
      7'h03:                      return 3;
      7'h23:                      return 4;
      7'h63, 7'h6F, 7'h67:        return 5;
      default:                    return 6;
    endcase
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  assign m_ret = valid_wb_i && !stall_wb_i && (instr_wb_i != NOP_I);

  // Reference model, advanced on every clock edge from the current inputs.
  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 7; i++) m_cnt[i] <= 0;
      m_rd <= 0; m_pos <= 0; m_acc <= 0; m_wret <= 0; m_done <= 1'b0;
    end else begin
      m_rd <= (sel_i < 3'd7) ? m_cnt[sel_i] : 0;
      if (clear_i) begin
        for (int i = 0; i < 7; i++) m_cnt[i] <= 0;
        m_pos <= 0; m_acc <= 0; m_done <= 1'b0;
      end else if (freeze_i) begin
        m_done <= 1'b0;
      end else begin
        m_cnt[0] <= sat(m_cnt[0] + 1);
        if (m_ret) begin
          m_cnt[1] <= sat(m_cnt[1] + 1);
          m_cnt[op_class(instr_wb_i)] <= sat(m_cnt[op_class(instr_wb_i)] + 1);
        end
        if (m_pos == W - 1) begin
          m_pos <= 0; m_acc <= 0; m_done <= 1'b1;
          m_wret <= sat(m_acc + int'(m_ret));
        end else begin
          m_pos <= m_pos + 1; m_done <= 1'b0;
          m_acc <= sat(m_acc + int'(m_ret));
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("rd_data", rd_data_o, m_rd);
      chk("window_done", window_done_o, WIN_EN ? int'(m_done) : 0);
      chk("window_retire", window_retire_o, WIN_EN ? m_wret : 0);
    end
  end

  task automatic drive(input bit v, input bit st, input logic [31:0] ins,
                       input bit clr, input bit frz, input logic [2:0] s);
    @(posedge clk_i);
    #2;
    valid_wb_i = v; stall_wb_i = st; instr_wb_i = ins;
    clear_i = clr; freeze_i = frz; sel_i = s;
  endtask

  task automatic idle(input logic [2:0] s);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, s);
  endtask

  task automatic clr();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'd0);
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] s, input int exp);
    idle(s);
    idle(s);
    chk(nm, rd_data_o, exp);
  endtask

  logic [31:0] rnd;
  logic [6:0]  rop;

  initial begin
    #1 reset_n_i = 1'b0;
    #2;
    chk("reset_rd", rd_data_o, 0);
    chk("reset_done", window_done_o, 0);
    chk("reset_wret", window_retire_o, 0);
    #9 reset_n_i = 1'b1;
    cmp_en = 1'b1;

    // Alternating ALU/load retires, then a valid NOP.
    clr();
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, (i % 2 == 0) ? ALU_I : LD_I, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, NOP_I, 1'b0, 1'b0, 3'd0);
    rd_chk("retire10", 3'd1, 10);
    rd_chk("alu5", 3'd2, 5);
    rd_chk("load5", 3'd3, 5);
    rd_chk("other0", 3'd6, 0);
    rd_chk("sel7", 3'd7, 0);

    // Stalled store retires only once released.
    clr();
    repeat (4) drive(1'b1, 1'b1, ST_I, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, ST_I, 1'b0, 1'b0, 3'd0);
    rd_chk("store1", 3'd4, 1);
    rd_chk("retire1", 3'd1, 1);

    // Saturation of the 8-bit cycle counter.
    clr();
    repeat (300) idle(3'd0);
    rd_chk("cycle_sat", 3'd0, 255);

    // Clear wins over a same-edge retire; freeze holds everything.
    clr();
    repeat (50) drive(1'b1, 1'b0, ALU_I, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, ALU_I, 1'b1, 1'b0, 3'd0);
    repeat (20) drive(1'b1, 1'b0, ALU_I, 1'b0, 1'b1, 3'd0);
    chk("freeze_cycle", rd_data_o, 0);
    drive(1'b1, 1'b0, ALU_I, 1'b0, 1'b1, 3'd2);
    drive(1'b1, 1'b0, ALU_I, 1'b0, 1'b1, 3'd1);
    chk("clear_alu", rd_data_o, 0);
    drive(1'b1, 1'b0, ALU_I, 1'b0, 1'b1, 3'd1);
    chk("clear_retire", rd_data_o, 0);
    rd_chk("frozen_alu", 3'd2, 0);

    // Window of 8 counted edges carrying 3 retires.
    clr();
    for (int i = 0; i < 8; i++) begin
      drive((i == 0 || i == 3 || i == 5), 1'b0, ALU_I, 1'b0, 1'b0, 3'd0);
    end
    chk("win_early", window_done_o, 0);
    idle(3'd0);
    chk("win_done", window_done_o, WIN_EN ? 1 : 0);
    chk("win_ret3", window_retire_o, WIN_EN ? 3 : 0);
    idle(3'd0);
    chk("win_pulse_end", window_done_o, 0);

    // Asynchronous reset mid-window.
    clr();
    repeat (3) idle(3'd0);
    @(posedge clk_i);
    #4 reset_n_i = 1'b0;
    #1;
    chk("async_rd", rd_data_o, 0);
    chk("async_done", window_done_o, 0);
    chk("async_wret", window_retire_o, 0);
    #1 reset_n_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle(3'd0);
      chk("post_reset_done", window_done_o, (WIN_EN && i == 7) ? 1 : 0);
    end

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom();
      case ($urandom_range(0, 11))
        0: rop = 7'h33;  1: rop = 7'h13;  2: rop = 7'h17;  3: rop = 7'h37;
        4: rop = 7'h63;  5: rop = 7'h6F;  6: rop = 7'h67;  7: rop = 7'h03;
        8: rop = 7'h23;  9: rop = 7'h0F;  10: rop = 7'h73;
        default: rop = 7'h13;
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            ($urandom_range(0, 9) == 0) ? NOP_I : {rnd[31:7], rop},
            $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
            3'($urandom_range(0, 7)));
    end
    idle(3'd0);
    idle(3'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/perf_counter_unit.md
PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, width of every event counter and of rd_data_o (legal 8..64).
REQ-002 SHALL have parameter WINDOW_CYCLES, default 1000, length of the sampling window in counted cycles (legal 2..2^CNT_WIDTH-1).
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n_i  input  1  asynchronous active-low reset.
REQ-005 SHALL have port valid_wb_i  input  1  writeback stage holds a valid instruction.
REQ-006 SHALL have port stall_wb_i  input  1  writeback stage stalled.
REQ-007 SHALL have port instr_wb_i  input  32  instruction word in writeback.
REQ-008 SHALL have port clear_i  input  1  synchronous clear of all counters and window state.
REQ-009 SHALL have port freeze_i  input  1  hold all counters and window state.
REQ-010 SHALL have port sel_i  input  3  readback counter select.
REQ-011 SHALL have port rd_data_o  output  CNT_WIDTH  registered readback value.
REQ-012 SHALL have port window_done_o  output  1  one-cycle pulse at window end.
REQ-013 SHALL have port window_retire_o  output  CNT_WIDTH  retire count of the last completed window.

Function
REQ-014 SHALL define retire = valid_wb_i & ~stall_wb_i & (instr_wb_i != 32'h00000013).
REQ-015 SHALL hold seven counters: 0 cycle, 1 retire, 2 alu, 3 load, 4 store, 5 branch, 6 other.
REQ-016 SHALL increment cycle every edge where clear_i=0 and freeze_i=0.
REQ-017 SHALL on retire increment retire plus exactly one class counter by opcode instr_wb_i[6:0]: 0110011/0010011/0010111/0110111 -> alu; 1100011/1101111/1100111 -> branch; 0000011 -> load; 0100011 -> store; any other -> other.
REQ-018 SHALL saturate every counter at 2^CNT_WIDTH-1; no wrap.
REQ-019 SHALL give clear_i priority over freeze_i and over any increment on the same edge; counters read 0 the next cycle.
REQ-020 SHALL with freeze_i=1 hold every counter, window counter and window accumulator; retires during freeze are lost.
REQ-021 SHALL register rd_data_o = counter[sel_i] sampled at the edge (1-cycle latency, value pre-increment of that edge); sel_i=7 returns 0.
REQ-022 SHALL keep a window cycle counter (0..WINDOW_CYCLES-1) and window retire accumulator advancing under the REQ-016/REQ-017 conditions.
REQ-023 SHALL on the counted edge where window counter equals WINDOW_CYCLES-1: reset window counter to 0, load window_retire_o with accumulator plus that edge's retire (saturated), zero accumulator, assert window_done_o for exactly the following cycle.
REQ-024 SHALL on clear_i zero window counter and accumulator, leave window_retire_o unchanged, and not pulse window_done_o.

Reset
REQ-025 SHALL on reset_n_i=0 asynchronously zero all counters, window state, rd_data_o, window_retire_o and window_done_o.
REQ-026 SHALL restart counting on the first rising edge after reset_n_i deassertion; reset mid-window discards the partial window.

Configuration
REQ-027 SHALL compile window logic (REQ-022..REQ-024) only when macro PERF_WINDOW_EN is defined.
REQ-028 SHALL without PERF_WINDOW_EN tie window_done_o to 0 and window_retire_o to 0, with no window registers; REQ-014..REQ-021 unchanged.

Verification
REQ-029 SHALL cover: 10 retires alternating R-type 0x00B50533 and load 0x0005A503 with no stall -> retire=10, alu=5, load=5; NOP 0x00000013 with valid -> no count.
REQ-030 SHALL cover: valid_wb_i=1, stall_wb_i=1 for 4 cycles on store 0x00B52023 then stall released 1 cycle -> store=1, retire=1.
REQ-031 SHALL cover: CNT_WIDTH=8, 300 cycles unfrozen -> cycle counter reads 255 via sel_i=0.
REQ-032 SHALL cover: clear_i and retire asserted on same edge after 50 cycles -> all counters 0; freeze_i for 20 cycles -> cycle counter unchanged.
REQ-033 SHALL cover (PERF_WINDOW_EN, WINDOW_CYCLES=8): 3 retires within 8 cycles -> window_done_o high exactly one cycle after 8th counted edge, window_retire_o=3.
REQ-034 SHALL cover: reset_n_i pulsed low between edges mid-window -> outputs 0 immediately, no window_done_o until 8 further counted cycles.
